// File: rtl/if_stage_prefetch_if.sv
// Bundle of the fetch-stage signals: execute-stage redirect, hazard freeze,
// instruction-memory request/response channel and the decoded-side outputs.
// The master side is the fetch stage; the slave side is its environment.
interface if_stage_prefetch_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   branch_taken;
    logic [ADDR_WIDTH-1:0]  branch_address;
    logic                   freeze;

    logic                   imem_req;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic                   imem_ready;
    logic                   imem_rvalid;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    logic                   instruction_valid;
    logic [INSTR_WIDTH-1:0] instruction;
    logic [ADDR_WIDTH-1:0]  pc;

    modport master (
        input  branch_taken,
        input  branch_address,
        input  freeze,
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata,
        output instruction_valid,
        output instruction,
        output pc
    );

    modport slave (
        output branch_taken,
        output branch_address,
        output freeze,
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata,
        input  instruction_valid,
        input  instruction,
        input  pc
    );
endinterface

// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage with an in-order prefetch queue.
// Requests are issued against a credit of DEPTH (queue entries plus requests
// in flight), so every response always has a free queue slot. A taken branch
// flushes the queue, redirects fetch and marks every in-flight response as
// stale; stale responses are counted down and discarded on arrival.
module if_stage_prefetch #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    if_stage_prefetch_if.master  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0]         CNT_ONE_C = CW'(1);
    localparam logic [PW-1:0]         PTR_ONE_C = PW'(1);
    localparam logic [CW:0]           DEPTH_C   = (CW + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP_C    = ADDR_WIDTH'(4);

    // Fetch / response bookkeeping
    logic [ADDR_WIDTH-1:0]  fetch_pc_r;
    logic [ADDR_WIDTH-1:0]  resp_pc_r;
    logic [CW-1:0]          outstanding_r;
    logic [CW-1:0]          drop_cnt_r;

    // Queue control and storage; the stored address is already head.addr + 4
    logic [CW-1:0]          count_r;
    logic [PW-1:0]          rd_ptr_r;
    logic [PW-1:0]          wr_ptr_r;
    logic [ADDR_WIDTH-1:0]  q_pc_r    [DEPTH];
    logic [INSTR_WIDTH-1:0] q_instr_r [DEPTH];

    logic [CW:0]            credit_sum_s;
    logic                   credit_ok_s;
    logic                   req_s;
    logic                   accept_s;
    logic                   rsp_s;
    logic                   drop_s;
    logic                   push_s;
    logic                   pop_s;
    logic [ADDR_WIDTH-1:0]  target_s;
    logic [CW-1:0]          outstanding_nxt_s;
    logic [CW-1:0]          count_nxt_s;
    logic                   unused_s;

    // Credit: queue occupancy plus in-flight requests may never exceed DEPTH
    assign credit_sum_s = {1'b0, outstanding_r} + {1'b0, count_r};
    assign credit_ok_s  = (credit_sum_s < DEPTH_C);

    assign req_s    = !rst && !bus.branch_taken && credit_ok_s;
    assign accept_s = req_s && bus.imem_ready;

    // A response with nothing in flight is a memory protocol error; ignoring
    // it keeps the counters from wrapping.
    assign rsp_s  = bus.imem_rvalid && (outstanding_r != {CW{1'b0}});
    assign drop_s = rsp_s && (drop_cnt_r != {CW{1'b0}});
    assign push_s = rsp_s && (drop_cnt_r == {CW{1'b0}}) && !bus.branch_taken;
    assign pop_s  = (count_r != {CW{1'b0}}) && !bus.freeze && !bus.branch_taken;

    assign target_s = {bus.branch_address[ADDR_WIDTH-1:2], 2'b00};

    // Low address bits of the redirect target are forced to zero
    assign unused_s = ^bus.branch_address[1:0];

    assign outstanding_nxt_s = outstanding_r + CW'(accept_s) - CW'(rsp_s);

    // Queue occupancy after this cycle's push/pop (branch flush handled in the register block)
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Fetch PC, response PC, credit counters and queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            drop_cnt_r    <= {CW{1'b0}};
            count_r       <= {CW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
        end else begin
            outstanding_r <= outstanding_nxt_s;
            if (bus.branch_taken) begin
                // Everything currently in flight is wrong-path, except a
                // response landing this very cycle, which is dropped here.
                fetch_pc_r <= target_s;
                resp_pc_r  <= target_s;
                drop_cnt_r <= outstanding_r - CW'(rsp_s);
                count_r    <= {CW{1'b0}};
                rd_ptr_r   <= {PW{1'b0}};
                wr_ptr_r   <= {PW{1'b0}};
            end else begin
                if (accept_s) begin
                    fetch_pc_r <= fetch_pc_r + STEP_C;
                end
                if (drop_s) begin
                    drop_cnt_r <= drop_cnt_r - CNT_ONE_C;
                end
                if (push_s) begin
                    wr_ptr_r  <= wr_ptr_r + PTR_ONE_C;
                    resp_pc_r <= resp_pc_r + STEP_C;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
                end
                count_r <= count_nxt_s;
            end
        end
    end

    // Queue storage; cleared on reset so the head reads instruction 0, pc 4
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_r[i]    <= STEP_C;
                q_instr_r[i] <= {INSTR_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            q_pc_r[wr_ptr_r]    <= resp_pc_r + STEP_C;
            q_instr_r[wr_ptr_r] <= bus.imem_rdata;
        end
    end

    // Outputs: request is combinational by design, queue outputs come straight from registers
    assign bus.imem_req          = req_s;
    assign bus.imem_addr         = fetch_pc_r;
    assign bus.instruction_valid = (count_r != {CW{1'b0}});
    assign bus.instruction       = q_instr_r[rd_ptr_r];
    assign bus.pc                = q_pc_r[rd_ptr_r];

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Bench for if_stage_prefetch: directed scenarios followed by random traffic.
// A behavioural memory returns responses in order after a chosen latency;
// the reference model tracks the architectural fetch stream with queues and
// a branch epoch tag on each request.
module tb_if_stage_prefetch;

    localparam int          AW       = 32;
    localparam int          IW       = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    if_stage_prefetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

    if_stage_prefetch #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    req_t        mem_q[$];
    logic [31:0] occ_q[$];
    int          cyc     = 0;
    int          epoch   = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] exp_fetch;

    // Values sampled at the most recent negedge
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge, then advance model and memory after posedge
    task automatic cycle();
        logic        acc, rsp, pop, br, exp_req;
        logic [31:0] acc_addr, tgt;
        req_t        r;
        @(negedge clk);
        s_req   = bus.imem_req;
        s_valid = bus.instruction_valid;
        s_addr  = bus.imem_addr;
        s_pc    = bus.pc;
        s_instr = bus.instruction;

        exp_req = !rst && !bus.branch_taken && ((mem_q.size() + occ_q.size()) < DEPTH);
        chk1("imem_req", bus.imem_req, exp_req);
        if (exp_req) chk32("imem_addr", bus.imem_addr, exp_fetch);
        chk1("instruction_valid", bus.instruction_valid, occ_q.size() != 0);
        if (occ_q.size() != 0) begin
            chk32("pc", bus.pc, occ_q[0] + 32'd4);
            chk32("instruction", bus.instruction, instr_of(occ_q[0]));
        end

        acc      = bus.imem_req && bus.imem_ready;
        acc_addr = bus.imem_addr;
        rsp      = bus.imem_rvalid;
        br       = bus.branch_taken;
        pop      = (occ_q.size() != 0) && !bus.freeze && !br;
        tgt      = {bus.branch_address[31:2], 2'b00};

        @(posedge clk);
        #1;
        if (rst) begin
            mem_q.delete();
            occ_q.delete();
            exp_fetch = RESET_PC;
            epoch++;
        end else begin
            if (pop) void'(occ_q.pop_front());
            if (rsp && mem_q.size() != 0) begin
                r = mem_q.pop_front();
                if (!br && r.epoch == epoch) occ_q.push_back(r.addr);
            end
            if (acc) mem_q.push_back('{addr: acc_addr,
                                       due: cyc + int'($urandom_range(lat_max, lat_min)),
                                       epoch: epoch});
            if (br) begin
                occ_q.delete();
                epoch++;
                exp_fetch = tgt;
            end else if (acc) begin
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        cyc++;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = instr_of(mem_q[0].addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
    endtask

    // Run until the queue head is valid, bounded
    task automatic wait_valid(input string tag);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!s_valid && n < 30);
        chk1(tag, s_valid, 1'b1);
    endtask

    initial begin
        rst                = 1'b1;
        bus.branch_taken   = 1'b0;
        bus.branch_address = 32'h0;
        bus.freeze         = 1'b0;
        bus.imem_ready     = 1'b1;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        exp_fetch          = RESET_PC;

        // Reset and sequential fetch, 1-cycle memory
        repeat (3) cycle();
        chk1("rst_req", s_req, 1'b0);
        chk1("rst_valid", s_valid, 1'b0);
        chk32("rst_instr", s_instr, 32'h0);
        chk32("rst_pc", s_pc, 32'd4);
        rst = 1'b0;
        cycle();
        chk1("seq_first_req", s_req, 1'b1);
        chk32("seq_first_addr", s_addr, RESET_PC);
        chk1("seq_valid_c0", s_valid, 1'b0);
        cycle();
        chk1("seq_valid_c1", s_valid, 1'b0);
        cycle();
        chk1("seq_valid_c2", s_valid, 1'b1);
        chk32("seq_pc_c2", s_pc, 32'd4);
        for (int i = 1; i <= 6; i++) begin
            cycle();
            chk1("seq_stream_valid", s_valid, 1'b1);
            chk32("seq_stream_pc", s_pc, 32'd4 + 32'(4 * i));
        end

        // Freeze back-pressure fills the queue, then drains without gaps
        rst = 1'b1;
        bus.freeze = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (8) cycle();
        chk1("frz_req_low", s_req, 1'b0);
        chk1("frz_valid", s_valid, 1'b1);
        chk32("frz_head_pc", s_pc, 32'd4);
        bus.freeze = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk1("frz_drain_valid", s_valid, 1'b1);
            chk32("frz_drain_pc", s_pc, 32'd4 + 32'(4 * i));
        end

        // Branch with two requests in flight, 3-cycle memory
        lat_min = 3;
        lat_max = 3;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        bus.branch_taken   = 1'b1;
        bus.branch_address = 32'h0000_0103;
        cycle();
        chk1("br_cycle_req", s_req, 1'b0);
        bus.branch_taken = 1'b0;
        cycle();
        chk1("br_next_req", s_req, 1'b1);
        chk32("br_next_addr", s_addr, 32'h0000_0100);
        wait_valid("br_first_valid");
        chk32("br_first_pc", s_pc, 32'h0000_0104);

        // Branch together with freeze and an arriving response
        lat_min = 2;
        lat_max = 2;
        bus.freeze = 1'b1;
        for (int n = 0; n < 20 && !(bus.imem_rvalid && mem_q.size() >= 2); n++) cycle();
        bus.branch_taken   = 1'b1;
        bus.branch_address = 32'h0000_2002;
        cycle();
        chk1("brf_cycle_req", s_req, 1'b0);
        bus.branch_taken = 1'b0;
        cycle();
        chk1("brf_flushed", s_valid, 1'b0);
        chk1("brf_next_req", s_req, 1'b1);
        chk32("brf_next_addr", s_addr, 32'h0000_2000);
        bus.freeze = 1'b0;
        wait_valid("brf_first_valid");
        chk32("brf_first_pc", s_pc, 32'h0000_2004);

        // Memory not ready for 5 cycles: fetch address must hold
        lat_min = 1;
        lat_max = 1;
        repeat (3) cycle();
        bus.imem_ready = 1'b0;
        begin
            logic [31:0] held;
            held = exp_fetch;
            for (int i = 0; i < 5; i++) begin
                cycle();
                chk32("rdy_hold_addr", s_addr, held);
            end
        end
        bus.imem_ready = 1'b1;
        repeat (6) cycle();

        // Reset with a full queue
        bus.freeze = 1'b1;
        repeat (10) cycle();
        chk1("mrst_full_valid", s_valid, 1'b1);
        chk1("mrst_full_req", s_req, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.freeze = 1'b0;
        cycle();
        chk1("mrst_valid", s_valid, 1'b0);
        chk32("mrst_instr", s_instr, 32'h0);
        chk32("mrst_pc", s_pc, 32'd4);
        chk1("mrst_req", s_req, 1'b1);
        chk32("mrst_addr", s_addr, RESET_PC);

        // Random traffic: freeze, ready, branches, variable latency, rare resets
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            bus.freeze         = ($urandom_range(3, 0) == 0);
            bus.imem_ready     = ($urandom_range(3, 0) != 0);
            bus.branch_taken   = ($urandom_range(19, 0) == 0);
            bus.branch_address = $urandom;
            rst                = ($urandom_range(499, 0) == 0);
            cycle();
        end
        rst              = 1'b0;
        bus.branch_taken = 1'b0;
        bus.freeze       = 1'b0;
        bus.imem_ready   = 1'b1;
        repeat (20) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
